// File: rtl/pulse_stretcher.sv
// Pulse stretcher: holds each new output level for a minimum number of enable
// ticks so that a far-end debouncer with the same counts accepts every edge.
module pulse_stretcher #(
   parameter int unsigned COUNT      = 1,
   parameter int unsigned HIGH_COUNT = COUNT,
   parameter int unsigned LOW_COUNT  = COUNT
) (
   input  logic clock_i,
   input  logic reset_ni,
   input  logic enable_i,
   input  logic in_i,
   output logic out_o,
   output logic busy_o,
   output logic changed_o
);

   localparam int unsigned HIGH_W = $clog2(HIGH_COUNT);
   localparam int unsigned LOW_W  = $clog2(LOW_COUNT);
   localparam int unsigned CNT_W  = ((HIGH_W > LOW_W) ? HIGH_W : LOW_W) + 1;

   localparam logic [CNT_W-1:0] HIGH_LOAD = CNT_W'(HIGH_COUNT);
   localparam logic [CNT_W-1:0] LOW_LOAD  = CNT_W'(LOW_COUNT);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   logic [1:0]       in_sync_q;
   state_t           state_q, state_d;
   logic             out_q, out_d;
   logic             changed_q, changed_d;
   logic             busy_q;
   logic [CNT_W-1:0] counter_q, counter_d;

   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         in_sync_q <= 2'b00;
         state_q   <= IDLE;
         out_q     <= 1'b0;
         changed_q <= 1'b0;
         busy_q    <= 1'b0;
         counter_q <= '0;
      end else begin
         in_sync_q <= {in_sync_q[0], in_i};
         state_q   <= state_d;
         out_q     <= out_d;
         changed_q <= changed_d;
         busy_q    <= (state_d == HOLD);
         counter_q <= counter_d;
      end
   end

   // The counter is loaded on the toggle edge; ticks only count from the next cycle on.
   always_comb begin
      state_d   = state_q;
      out_d     = out_q;
      changed_d = 1'b0;
      counter_d = counter_q;
      if (state_q == IDLE) begin
         if (in_sync_q[1] != out_q) begin
            out_d     = in_sync_q[1];
            changed_d = 1'b1;
            counter_d = in_sync_q[1] ? HIGH_LOAD : LOW_LOAD;
            state_d   = HOLD;
         end
      end else begin
         if (enable_i) begin
            counter_d = counter_q - CNT_ONE;
            if (counter_q == CNT_ONE) begin
               state_d = IDLE;
            end
         end
      end
   end

   assign out_o     = out_q;
   assign busy_o    = busy_q;
   assign changed_o = changed_q;

endmodule
